// File: rtl/mem_loader_if.sv
// Byte-stream input, external data-memory write port and session status of the memory loader.
// The loader drives the master side; the byte source, memory and CPU sit on the slave side.
interface mem_loader_if;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        Ext_MemWrite;
    logic [31:0] Ext_DataAdr;
    logic [31:0] Ext_WriteData;
    logic        cpu_reset;
    logic        busy;
    logic        done;

    modport master (
        input  start,
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output Ext_MemWrite,
        output Ext_DataAdr,
        output Ext_WriteData,
        output cpu_reset,
        output busy,
        output done
    );

    modport slave (
        output start,
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  Ext_MemWrite,
        input  Ext_DataAdr,
        input  Ext_WriteData,
        input  cpu_reset,
        input  busy,
        input  done
    );
endinterface

// File: rtl/mem_loader.sv
// Collects a little-endian byte stream into 32-bit words and writes WORD_COUNT of them to data
// memory from BASE_ADR upward while holding the CPU in reset; releases the CPU when finished.
module mem_loader #(
    parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
    parameter int unsigned WORD_COUNT = 64
) (
    input logic          clk,
    input logic          reset,
    mem_loader_if.master bus
);

    typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

    localparam logic [15:0] LastCount = WORD_COUNT[15:0];

    state_e      state_q;
    logic [31:0] adr_q;
    logic [15:0] word_cnt_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] asm_q;
    logic        rx_ready_q;
    logic        mem_write_q;
    logic [31:0] ext_adr_q;
    logic [31:0] wdata_q;
    logic        busy_q;
    logic        done_q;
    logic        cpu_reset_q;
    logic [15:0] word_cnt_inc;

    assign word_cnt_inc = word_cnt_q + 16'd1;

    // All outputs are registered and set alongside the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            adr_q       <= BASE_ADR;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            rx_ready_q  <= 1'b0;
            mem_write_q <= 1'b0;
            ext_adr_q   <= BASE_ADR;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state_q     <= StCollect;
                        adr_q       <= BASE_ADR;
                        ext_adr_q   <= BASE_ADR;
                        word_cnt_q  <= '0;
                        byte_cnt_q  <= '0;
                        asm_q       <= '0;
                        rx_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        cpu_reset_q <= 1'b1;
                    end
                end
                StCollect: begin
                    if (bus.rx_valid) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            // Fourth byte goes straight into the write word, saving a cycle.
                            state_q     <= StWrite;
                            wdata_q     <= {bus.rx_data, asm_q[23:0]};
                            ext_adr_q   <= adr_q;
                            mem_write_q <= 1'b1;
                            rx_ready_q  <= 1'b0;
                        end else begin
                            asm_q[{byte_cnt_q, 3'b000} +: 8] <= bus.rx_data;
                        end
                    end
                end
                StWrite: begin
                    mem_write_q <= 1'b0;
                    adr_q       <= adr_q + 32'd4;
                    word_cnt_q  <= word_cnt_inc;
                    if (word_cnt_inc == LastCount) begin
                        state_q     <= StDone;
                        rx_ready_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b0;
                    end else begin
                        state_q    <= StCollect;
                        rx_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.rx_ready      = rx_ready_q;
    assign bus.Ext_MemWrite  = mem_write_q;
    assign bus.Ext_DataAdr   = ext_adr_q;
    assign bus.Ext_WriteData = wdata_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.cpu_reset     = cpu_reset_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected writes are queued as bytes are driven and popped
// whenever a DUT pulses Ext_MemWrite. Instance a starts at 0, instance b at 0xFFFFFFFC.
module tb_mem_loader;

    logic clk;
    logic reset;

    mem_loader_if a_if ();
    mem_loader_if b_if ();

    mem_loader #(
        .BASE_ADR  (32'h0000_0000),
        .WORD_COUNT(2)
    ) u_dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (a_if)
    );

    mem_loader #(
        .BASE_ADR  (32'hFFFF_FFFC),
        .WORD_COUNT(2)
    ) u_dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_a = 0;
    int wr_b = 0;
    int last_wr_a = 0;
    int last_wr_b = 0;
    logic [63:0] qa[$];
    logic [63:0] qb[$];

    // Advances to the next falling edge and scores any write either DUT is presenting.
    task automatic tick();
        logic [63:0] exp;
        @(negedge clk);
        cyc++;
        if (a_if.Ext_MemWrite === 1'b1) begin
            wr_a++;
            last_wr_a = cyc;
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL a_write_unexpected: got adr=%h data=%h, required no write",
                         a_if.Ext_DataAdr, a_if.Ext_WriteData);
            end else begin
                exp = qa.pop_front();
                if ({a_if.Ext_DataAdr, a_if.Ext_WriteData} !== exp) begin
                    bad++;
                    $display("FAIL a_write: got adr=%h data=%h, required adr=%h data=%h",
                             a_if.Ext_DataAdr, a_if.Ext_WriteData, exp[63:32], exp[31:0]);
                end
            end
        end
        if (b_if.Ext_MemWrite === 1'b1) begin
            wr_b++;
            last_wr_b = cyc;
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL b_write_unexpected: got adr=%h data=%h, required no write",
                         b_if.Ext_DataAdr, b_if.Ext_WriteData);
            end else begin
                exp = qb.pop_front();
                if ({b_if.Ext_DataAdr, b_if.Ext_WriteData} !== exp) begin
                    bad++;
                    $display("FAIL b_write: got adr=%h data=%h, required adr=%h data=%h",
                             b_if.Ext_DataAdr, b_if.Ext_WriteData, exp[63:32], exp[31:0]);
                end
            end
        end
    endtask

    task automatic do_start(input bit sel);
        if (sel) b_if.start = 1'b1;
        else     a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        b_if.start = 1'b0;
    endtask

    // Sends the low nbytes of word, LSB first; gap inserts an idle cycle after each byte.
    task automatic send_word(input bit sel, input logic [31:0] word, input bit gap,
                             input int nbytes);
        logic [31:0] w;
        bit          acc;
        int          n;
        w = word;
        for (int i = 0; i < nbytes; i++) begin
            acc = 1'b0;
            n   = 0;
            while (!acc) begin
                if (sel) begin
                    b_if.rx_valid = 1'b1;
                    b_if.rx_data  = w[7:0];
                    acc = (b_if.rx_ready === 1'b1);
                end else begin
                    a_if.rx_valid = 1'b1;
                    a_if.rx_data  = w[7:0];
                    acc = (a_if.rx_ready === 1'b1);
                end
                tick();
                n++;
                if (!acc && n > 20) begin
                    total++;
                    bad++;
                    $display("FAIL byte_accept_timeout: got rx_ready=0 for %0d cycles, required 1", n);
                    acc = 1'b1;
                end
            end
            w = w >> 8;
            if (gap) begin
                a_if.rx_valid = 1'b0;
                b_if.rx_valid = 1'b0;
                tick();
            end
        end
    endtask

    task automatic wait_done(input bit sel, output int done_cyc);
        int n;
        n = 0;
        done_cyc = -1;
        while (done_cyc < 0 && n < 20) begin
            tick();
            n++;
            if ((sel ? b_if.done : a_if.done) === 1'b1) done_cyc = cyc;
        end
        if (done_cyc < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got done=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        total++;
        if ({a_if.Ext_MemWrite, a_if.rx_ready, a_if.busy, a_if.done, a_if.cpu_reset}
            !== 5'b00001) begin
            bad++;
            $display("FAIL reset_ctrl: got we/rdy/busy/done/cpur=%b, required 00001",
                     {a_if.Ext_MemWrite, a_if.rx_ready, a_if.busy, a_if.done, a_if.cpu_reset});
        end
        total++;
        if ({a_if.Ext_DataAdr, a_if.Ext_WriteData} !== 64'h0) begin
            bad++;
            $display("FAIL reset_bus_a: got adr=%h data=%h, required 0/0",
                     a_if.Ext_DataAdr, a_if.Ext_WriteData);
        end
        total++;
        if (b_if.Ext_DataAdr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL reset_adr_b: got %h, required fffffffc", b_if.Ext_DataAdr);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_idle_valid();
        logic seen;
        seen = 1'b0;
        a_if.rx_valid = 1'b1;
        a_if.rx_data  = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_if.rx_ready !== 1'b0) seen = 1'b1;
        end
        a_if.rx_valid = 1'b0;
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL idle_rx_ready: got rx_ready=1 in IDLE, required 0");
        end
        total++;
        if (wr_a !== 0) begin
            bad++;
            $display("FAIL idle_writes: got %0d writes, required 0", wr_a);
        end
    endtask

    task automatic test_held();
        int w0;
        int dc;
        w0 = wr_a;
        do_start(1'b0);
        total++;
        if ({a_if.busy, a_if.cpu_reset, a_if.rx_ready, a_if.done} !== 4'b1110) begin
            bad++;
            $display("FAIL held_start: got busy/cpur/rdy/done=%b, required 1110",
                     {a_if.busy, a_if.cpu_reset, a_if.rx_ready, a_if.done});
        end
        qa.push_back({32'h0000_0000, 32'h1234_5678});
        qa.push_back({32'h0000_0004, 32'hDEAD_BEEF});
        send_word(1'b0, 32'h1234_5678, 1'b0, 4);
        send_word(1'b0, 32'hDEAD_BEEF, 1'b0, 4);
        a_if.rx_valid = 1'b0;
        wait_done(1'b0, dc);
        total++;
        if (dc !== last_wr_a + 1) begin
            bad++;
            $display("FAIL held_done_latency: got done at cycle %0d, required %0d",
                     dc, last_wr_a + 1);
        end
        total++;
        if ({a_if.cpu_reset, a_if.busy} !== 2'b00) begin
            bad++;
            $display("FAIL held_release: got cpur/busy=%b, required 00",
                     {a_if.cpu_reset, a_if.busy});
        end
        total++;
        if (wr_a - w0 !== 2 || qa.size() !== 0) begin
            bad++;
            $display("FAIL held_count: got %0d writes %0d pending, required 2 and 0",
                     wr_a - w0, qa.size());
        end
    endtask

    task automatic test_toggle();
        int w0;
        int dc;
        w0 = wr_a;
        do_start(1'b0);
        total++;
        if ({a_if.cpu_reset, a_if.busy, a_if.done} !== 3'b110 || a_if.Ext_DataAdr !== 32'h0) begin
            bad++;
            $display("FAIL restart_from_done: got cpur/busy/done=%b adr=%h, required 110 adr=0",
                     {a_if.cpu_reset, a_if.busy, a_if.done}, a_if.Ext_DataAdr);
        end
        qa.push_back({32'h0000_0000, 32'h1234_5678});
        qa.push_back({32'h0000_0004, 32'hDEAD_BEEF});
        send_word(1'b0, 32'h1234_5678, 1'b1, 4);
        send_word(1'b0, 32'hDEAD_BEEF, 1'b1, 4);
        wait_done(1'b0, dc);
        total++;
        if (wr_a - w0 !== 2 || qa.size() !== 0) begin
            bad++;
            $display("FAIL toggle_count: got %0d writes %0d pending, required 2 and 0",
                     wr_a - w0, qa.size());
        end
    endtask

    task automatic test_start_collect();
        int w0;
        int dc;
        w0 = wr_a;
        do_start(1'b0);
        qa.push_back({32'h0000_0000, 32'hA1B2_C3D4});
        qa.push_back({32'h0000_0004, 32'h0F1E_2D3C});
        send_word(1'b0, 32'h0000_C3D4, 1'b0, 2);
        a_if.rx_valid = 1'b0;
        do_start(1'b0);
        send_word(1'b0, 32'h0000_A1B2, 1'b0, 2);
        send_word(1'b0, 32'h0F1E_2D3C, 1'b0, 4);
        a_if.rx_valid = 1'b0;
        wait_done(1'b0, dc);
        total++;
        if (wr_a - w0 !== 2 || qa.size() !== 0) begin
            bad++;
            $display("FAIL start_in_collect: got %0d writes %0d pending, required 2 and 0",
                     wr_a - w0, qa.size());
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = wr_a;
        do_start(1'b0);
        qa.push_back({32'h0000_0000, 32'h1234_5678});
        send_word(1'b0, 32'h1234_5678, 1'b0, 4);
        send_word(1'b0, 32'hDEAD_BEEF, 1'b0, 2);
        a_if.rx_valid = 1'b0;
        reset = 1'b0;
        #1;
        total++;
        if ({a_if.Ext_MemWrite, a_if.rx_ready, a_if.busy, a_if.done, a_if.cpu_reset} !== 5'b00001
            || a_if.Ext_DataAdr !== 32'h0 || a_if.Ext_WriteData !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset: got ctrl=%b adr=%h data=%h, required 00001/0/0",
                     {a_if.Ext_MemWrite, a_if.rx_ready, a_if.busy, a_if.done, a_if.cpu_reset},
                     a_if.Ext_DataAdr, a_if.Ext_WriteData);
        end
        tick();
        reset = 1'b1;
        a_if.rx_valid = 1'b1;
        a_if.rx_data  = 8'h5A;
        for (int i = 0; i < 6; i++) tick();
        a_if.rx_valid = 1'b0;
        total++;
        if (wr_a - w0 !== 1 || a_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_no_resume: got %0d writes busy=%b, required 1 and 0",
                     wr_a - w0, a_if.busy);
        end
        do_start(1'b0);
        qa.push_back({32'h0000_0000, 32'hCAFE_F00D});
        send_word(1'b0, 32'hCAFE_F00D, 1'b0, 4);
        a_if.rx_valid = 1'b0;
        tick();
        tick();
        total++;
        if (wr_a - w0 !== 2 || qa.size() !== 0) begin
            bad++;
            $display("FAIL mid_reset_restart: got %0d writes %0d pending, required 2 and 0",
                     wr_a - w0, qa.size());
        end
    endtask

    task automatic test_wrap();
        int dc;
        do_start(1'b1);
        qb.push_back({32'hFFFF_FFFC, 32'h1122_3344});
        qb.push_back({32'h0000_0000, 32'h5566_7788});
        send_word(1'b1, 32'h1122_3344, 1'b0, 4);
        send_word(1'b1, 32'h5566_7788, 1'b0, 4);
        b_if.rx_valid = 1'b0;
        wait_done(1'b1, dc);
        total++;
        if (wr_b !== 2 || qb.size() !== 0 || b_if.cpu_reset !== 1'b0) begin
            bad++;
            $display("FAIL wrap: got %0d writes %0d pending cpur=%b, required 2, 0, 0",
                     wr_b, qb.size(), b_if.cpu_reset);
        end
    endtask

    initial begin
        reset         = 1'b0;
        a_if.start    = 1'b0;
        a_if.rx_valid = 1'b0;
        a_if.rx_data  = 8'h00;
        b_if.start    = 1'b0;
        b_if.rx_valid = 1'b0;
        b_if.rx_data  = 8'h00;
        test_reset();
        test_idle_valid();
        test_held();
        test_toggle();
        test_start_collect();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h0000_0000: byte address of the first word written.
REQ-002 SHALL have parameter WORD_COUNT, default 64: number of 32-bit words per load session; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: a high level in IDLE or DONE begins a load session.
REQ-006 SHALL have port rx_valid, input, 1: the byte source has a byte on rx_data.
REQ-007 SHALL have port rx_data, input, 8: the incoming byte.
REQ-008 SHALL have port rx_ready, output, 1: the loader accepts a byte this cycle.
REQ-009 SHALL have port Ext_MemWrite, output, 1: write strobe to the data memory external port.
REQ-010 SHALL have port Ext_DataAdr, output, 32: byte address for the external write.
REQ-011 SHALL have port Ext_WriteData, output, 32: word for the external write.
REQ-012 SHALL have port cpu_reset, output, 1: active-high hold of the CPU; the external write port is honoured only while it is high.
REQ-013 SHALL have port busy, output, 1: a session is in progress.
REQ-014 SHALL have port done, output, 1: the last session completed; the CPU is released.

Function
REQ-015 SHALL implement the FSM states IDLE, COLLECT, WRITE and DONE.
REQ-016 Byte handshake SHALL be: a byte is accepted on a clock edge where rx_valid && rx_ready; rx_ready is 1 only in COLLECT.
REQ-017 Word assembly SHALL be little-endian: the 1st accepted byte goes to [7:0], the 2nd to [15:8], the 3rd to [23:16] and the 4th to [31:24], using a 2-bit byte counter that wraps 3->0.
REQ-018 IDLE/DONE -> COLLECT SHALL occur on start=1, and on that transition:
- address is set to BASE_ADR;
- the word counter and byte counter are cleared;
- the assembly register is cleared;
- cpu_reset is 1.
REQ-019 COLLECT -> WRITE SHALL occur on the edge that accepts the 4th byte; the full word SHALL be visible on Ext_WriteData in the WRITE cycle.
REQ-020 In WRITE, Ext_MemWrite SHALL be 1 for exactly one cycle, with Ext_DataAdr equal to the current address.
REQ-021 On leaving WRITE, the address SHALL increment by 4, wrapping mod 2^32, and the word counter SHALL increment by 1.
REQ-022 WRITE -> DONE SHALL occur when the incremented word count equals WORD_COUNT; otherwise WRITE -> COLLECT.
REQ-023 Write latency SHALL be 1 cycle from acceptance of a word's 4th byte to the Ext_MemWrite pulse.
REQ-024 The minimum byte-to-byte spacing SHALL be 1 cycle within a word, with exactly one rx_ready=0 bubble per word during WRITE.
REQ-025 busy SHALL be 1 in COLLECT and WRITE only.
REQ-026 done SHALL be 1 in DONE only.
REQ-027 cpu_reset SHALL be 0 in DONE only and 1 in all other states.
REQ-028 start while in COLLECT or WRITE SHALL be ignored.
REQ-029 rx_valid outside COLLECT SHALL be ignored and the byte not consumed.
REQ-030 start in DONE SHALL re-enter COLLECT and re-assert cpu_reset on the next cycle.
REQ-031 Ext_WriteData and Ext_DataAdr SHALL hold their values when not in WRITE; only Ext_MemWrite qualifies them.

Reset
REQ-032 On reset=0 the FSM SHALL go to IDLE asynchronously with these output values:
- Ext_MemWrite=0;
- Ext_DataAdr=BASE_ADR;
- Ext_WriteData=0;
- rx_ready=0;
- busy=0;
- done=0;
- cpu_reset=1.
REQ-033 Reset asserted mid-session SHALL discard any partial word and SHALL issue no further write.
REQ-034 A session SHALL resume only after a new start.

Verification
REQ-035 Scenario: WORD_COUNT=2, start, bytes 78 56 34 12 EF BE AD DE, rx_valid held high -> writes 32'h12345678 @0x0 and 32'hDEADBEEF @0x4, one Ext_MemWrite cycle each, done=1 and cpu_reset=0 one cycle after the 2nd write.
REQ-036 Scenario: rx_valid toggling 1/0 every cycle -> identical write contents and addresses to the previous scenario, with no byte dropped or duplicated.
REQ-037 Scenario: BASE_ADR=32'hFFFF_FFFC, WORD_COUNT=2 -> writes at 0xFFFFFFFC then 0x00000000.
REQ-038 Scenario: reset pulled low after 2 bytes of the 2nd word -> outputs take their reset values immediately and no 2nd write occurs; a new start with 4 bytes writes to BASE_ADR.
REQ-039 Scenario: start pulsed during COLLECT -> no effect on the byte counter or address; start in DONE -> cpu_reset=1, busy=1 on the next cycle and the address is back at BASE_ADR.
REQ-040 Scenario: rx_valid=1 in IDLE for 10 cycles -> rx_ready=0 and no Ext_MemWrite.
